// File: rtl/merge8_scheduler_if.sv
// Handshake bundle between requesters, the shared merge network
// and the downstream consumer of merged results.
interface merge8_scheduler_if #(
    parameter int WIDTH = 3,
    parameter int NREQ  = 4,
    parameter int TAG_W = 2
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*8*WIDTH-1:0] req_data;
    logic [8*WIDTH-1:0]      net_inba;
    logic [8*WIDTH-1:0]      net_c;
    logic                    out_valid;
    logic                    out_ready;
    logic [8*WIDTH-1:0]      out_data;
    logic [TAG_W-1:0]        out_tag;
    logic                    out_err;
    logic                    busy;

    modport slave (
        input  req_valid,
        input  req_data,
        input  net_c,
        input  out_ready,
        output req_ready,
        output net_inba,
        output out_valid,
        output out_data,
        output out_tag,
        output out_err,
        output busy
    );

    modport master (
        output req_valid,
        output req_data,
        output net_c,
        output out_ready,
        input  req_ready,
        input  net_inba,
        input  out_valid,
        input  out_data,
        input  out_tag,
        input  out_err,
        input  busy
    );
endinterface

// File: rtl/merge8_scheduler.sv
// Round-robin scheduler time-sharing one combinational merge4to8
// network between NREQ requesters, returning tagged results.
module merge8_scheduler #(
    parameter int WIDTH = 3,
    parameter int NREQ  = 4,
    parameter int TAG_W = 2
) (
    input logic                clk,
    input logic                rst,
    merge8_scheduler_if.slave  bus
);
    localparam int DW = 8 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MERGE,
        S_OUT
    } state_e;

    state_e           state_q, state_d;
    logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [DW-1:0]    inba_q, inba_d;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_err_q, out_err_d;

    logic [DW-1:0]    req_arr [NREQ];
    logic             gnt_found;
    logic [TAG_W-1:0] gnt_idx;
    logic             gnt_cycle;
    logic             accept;
    logic             ops_err;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_arr[i] = bus.req_data[i*DW +: DW];
        end
    end

    // Search begins just after the last grant and wraps.
    always_comb begin
        int j;
        j         = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!gnt_found && bus.req_valid[TAG_W'(j)]) begin
                gnt_found = 1'b1;
                gnt_idx   = TAG_W'(j);
            end
        end
    end

    assign gnt_cycle = !rst &&
        ((state_q == S_IDLE) ||
         ((state_q == S_OUT) && bus.out_ready));
    assign accept    = gnt_cycle && gnt_found;

    always_comb begin
        bus.req_ready = '0;
        if (accept) bus.req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        ops_err = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (inba_q[k*WIDTH +: WIDTH] >
                inba_q[(k+1)*WIDTH +: WIDTH])
                ops_err = 1'b1;
            if (inba_q[(k+4)*WIDTH +: WIDTH] >
                inba_q[(k+5)*WIDTH +: WIDTH])
                ops_err = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        tag_d       = tag_q;
        inba_d      = inba_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            inba_d   = req_arr[gnt_idx];
            tag_d    = gnt_idx;
            rr_ptr_d = gnt_idx;
        end
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_MERGE;
            end
            S_MERGE: begin
                out_data_d  = bus.net_c;
                out_tag_d   = tag_q;
                out_err_d   = ops_err;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = accept ? S_MERGE : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= TAG_W'(NREQ - 1);
            tag_q       <= '0;
            inba_q      <= '0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            tag_q       <= tag_d;
            inba_q      <= inba_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.net_inba  = inba_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_err   = out_err_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_merge8_scheduler.sv
// Directed bench for merge8_scheduler; a sorting model stands in
// for the combinational merge network.
module tb_merge8_scheduler;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    merge8_scheduler_if #(.WIDTH(3), .NREQ(4), .TAG_W(2)) bus ();

    merge8_scheduler #(.WIDTH(3), .NREQ(4), .TAG_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] sort8(input logic [23:0] v);
        logic [2:0] e [8];
        logic [2:0] t;
        logic [23:0] r;
        for (int i = 0; i < 8; i++) e[i] = v[i*3 +: 3];
        for (int i = 0; i < 7; i++)
            for (int k = 0; k < 7 - i; k++)
                if (e[k] > e[k+1]) begin
                    t = e[k]; e[k] = e[k+1]; e[k+1] = t;
                end
        r = '0;
        for (int i = 0; i < 8; i++) r[i*3 +: 3] = e[i];
        return r;
    endfunction

    always_comb bus.net_c = sort8(bus.net_inba);

    function automatic logic [23:0] pack8(
        input int e0, input int e1, input int e2, input int e3,
        input int e4, input int e5, input int e6, input int e7);
        logic [23:0] r;
        r = {3'(e7), 3'(e6), 3'(e5), 3'(e4),
             3'(e3), 3'(e2), 3'(e1), 3'(e0)};
        return r;
    endfunction

    task automatic set_req(input int i, input logic [23:0] d);
        bus.req_data[i*24 +: 24] = d;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL rst_out_valid got=%0h exp=0", bus.out_valid);
            failures++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            $display("FAIL rst_busy got=%0h exp=0", bus.busy);
            failures++;
        end
        checks++;
        if (bus.req_ready !== 4'b0) begin
            $display("FAIL rst_req_ready got=%0h exp=0", bus.req_ready);
            failures++;
        end
        checks++;
        if (bus.out_data !== 24'h0 || bus.net_inba !== 24'h0) begin
            $display("FAIL rst_data got=%0h/%0h exp=0/0",
                     bus.out_data, bus.net_inba);
            failures++;
        end
        checks++;
        if (bus.out_tag !== 2'd0 || bus.out_err !== 1'b0) begin
            $display("FAIL rst_tag_err got=%0h/%0h exp=0/0",
                     bus.out_tag, bus.out_err);
            failures++;
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [23:0] d;
        d = pack8(0, 2, 5, 7, 1, 3, 4, 6);
        set_req(0, d);
        bus.req_valid = 4'b0001;
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            $display("FAIL single_ready got=%0h exp=1", bus.req_ready);
            failures++;
        end
        @(negedge clk);
        bus.req_valid = '0;
        checks++;
        if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            $display("FAIL single_merge got=%0h/%0h exp=1/0",
                     bus.busy, bus.out_valid);
            failures++;
        end
        checks++;
        if (bus.net_inba !== d) begin
            $display("FAIL single_inba got=%0h exp=%0h", bus.net_inba, d);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            $display("FAIL single_valid got=%0h exp=1", bus.out_valid);
            failures++;
        end
        checks++;
        if (bus.out_data !== 24'hFAC688) begin
            $display("FAIL single_data got=%0h exp=fac688", bus.out_data);
            failures++;
        end
        checks++;
        if (bus.out_tag !== 2'd0 || bus.out_err !== 1'b0) begin
            $display("FAIL single_tag_err got=%0h/%0h exp=0/0",
                     bus.out_tag, bus.out_err);
            failures++;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL single_idle got=%0h/%0h exp=0/0",
                     bus.out_valid, bus.busy);
            failures++;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_rdy;
        logic [1:0] exp_tag;
        apply_reset();
        for (int i = 0; i < 4; i++)
            set_req(i, pack8(i, 1, 2, 3, 4, 5, 6, 7));
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            exp_rdy = 4'b0001 << (i % 4);
            exp_tag = 2'((i + 3) % 4);
            checks++;
            if (bus.req_ready !== exp_rdy) begin
                $display("FAIL rr_grant%0d got=%0h exp=%0h",
                         i, bus.req_ready, exp_rdy);
                failures++;
            end
            if (i > 0) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_tag !== exp_tag) begin
                    $display("FAIL rr_tag%0d got=%0h/%0h exp=1/%0h",
                             i, bus.out_valid, bus.out_tag, exp_tag);
                    failures++;
                end
            end
            @(negedge clk);
            #1;
            checks++;
            if (bus.req_ready !== 4'b0 || bus.out_valid !== 1'b0) begin
                $display("FAIL rr_merge%0d got=%0h/%0h exp=0/0",
                         i, bus.req_ready, bus.out_valid);
                failures++;
            end
            @(negedge clk);
        end
        bus.req_valid = '0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_tag !== 2'd0) begin
            $display("FAIL rr_last got=%0h/%0h exp=1/0",
                     bus.out_valid, bus.out_tag);
            failures++;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_stall();
        logic [23:0] exp1;
        apply_reset();
        exp1 = pack8(0, 1, 1, 2, 3, 4, 6, 7);
        set_req(1, pack8(1, 1, 4, 6, 0, 2, 3, 7));
        set_req(2, pack8(0, 1, 2, 3, 4, 5, 6, 7));
        bus.req_valid = 4'b0010;
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0010) begin
            $display("FAIL stall_grant got=%0h exp=2", bus.req_ready);
            failures++;
        end
        @(negedge clk);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp1 ||
                bus.out_tag !== 2'd1 || bus.req_ready !== 4'b0) begin
                $display("FAIL stall_hold%0d got=%0h/%0h/%0h/%0h exp=1/%0h/1/0",
                         c, bus.out_valid, bus.out_data, bus.out_tag,
                         bus.req_ready, exp1);
                failures++;
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            $display("FAIL stall_release got=%0h exp=4", bus.req_ready);
            failures++;
        end
        @(negedge clk);
        bus.req_valid = '0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
            $display("FAIL stall_merge got=%0h/%0h exp=0/1",
                     bus.out_valid, bus.busy);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_tag !== 2'd2 ||
            bus.out_data !== 24'hFAC688) begin
            $display("FAIL stall_next got=%0h/%0h/%0h exp=1/2/fac688",
                     bus.out_valid, bus.out_tag, bus.out_data);
            failures++;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_err();
        logic [23:0] exp_d;
        exp_d = pack8(0, 1, 1, 2, 2, 3, 3, 5);
        set_req(2, pack8(5, 1, 2, 3, 0, 1, 2, 3));
        bus.req_valid = 4'b0100;
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            $display("FAIL err_grant got=%0h exp=4", bus.req_ready);
            failures++;
        end
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b1 ||
            bus.out_tag !== 2'd2) begin
            $display("FAIL err_flag got=%0h/%0h/%0h exp=1/1/2",
                     bus.out_valid, bus.out_err, bus.out_tag);
            failures++;
        end
        checks++;
        if (bus.out_data !== exp_d) begin
            $display("FAIL err_data got=%0h exp=%0h", bus.out_data, exp_d);
            failures++;
        end
        set_req(2, pack8(3, 3, 3, 3, 3, 3, 3, 3));
        bus.req_valid = 4'b0100;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            $display("FAIL eq_grant got=%0h exp=4", bus.req_ready);
            failures++;
        end
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 24'h6DB6DB ||
            bus.out_err !== 1'b0) begin
            $display("FAIL eq_data got=%0h/%0h/%0h exp=1/6db6db/0",
                     bus.out_valid, bus.out_data, bus.out_err);
            failures++;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_req(3, pack8(1, 2, 3, 4, 0, 5, 6, 7));
        set_req(0, pack8(0, 2, 5, 7, 1, 3, 4, 6));
        bus.req_valid = 4'b1000;
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 4'b1000) begin
            $display("FAIL rm_grant3 got=%0h exp=8", bus.req_ready);
            failures++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.req_ready !== 4'b0) begin
            $display("FAIL rm_flush got=%0h/%0h/%0h exp=0/0/0",
                     bus.out_valid, bus.busy, bus.req_ready);
            failures++;
        end
        rst = 1'b0;
        bus.req_valid = 4'b1001;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            $display("FAIL rm_prio got=%0h exp=1", bus.req_ready);
            failures++;
        end
        @(negedge clk);
        bus.req_valid = 4'b1000;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_tag !== 2'd0 ||
            bus.out_data !== 24'hFAC688) begin
            $display("FAIL rm_out0 got=%0h/%0h/%0h exp=1/0/fac688",
                     bus.out_valid, bus.out_tag, bus.out_data);
            failures++;
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b1000) begin
            $display("FAIL rm_grant3b got=%0h exp=8", bus.req_ready);
            failures++;
        end
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_tag !== 2'd3 ||
            bus.out_data !== 24'hFAC688) begin
            $display("FAIL rm_out3 got=%0h/%0h/%0h exp=1/3/fac688",
                     bus.out_valid, bus.out_tag, bus.out_data);
            failures++;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
